uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- Serial transmitter, the sending end of the 8N1 serial link whose receive path ends in the 9-bit packet/stop-bit shift register.
- Accepts one parallel byte per handshake and drives it onto a single serial line as one frame: start bit (0), 8 data bits LSB first, stop bit (1).
- Every bit is held for BIT_PERIOD clocks.
- Sits between the packet-source logic and the physical serial output.

Parameters:
- BIT_PERIOD, 10, clocks per serial bit; legal range 2..1023; counter width is clog2(BIT_PERIOD).
- DATA_BITS, 8, data bits per frame; fixed at 8 for this revision; the bench checks only 8.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_start  input  1  request to send tx_data; sampled only in IDLE.
- tx_data  input  8  byte to send; captured on the accepting edge only.
- tx_busy  output  1  high from the cycle after acceptance through the last stop-bit cycle.
- tx_done  output  1  one-cycle pulse, first cycle after the stop bit completes.
- serial_out  output  1  registered serial line; idle high.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. Ports are clk and rst; rst is sampled on the rising edge of clk.
- Reset values (rst=1 at an edge):
  - State = IDLE; serial_out=1; tx_busy=0; tx_done=0.
  - Bit counter and period counter = 0; shift register = 0.
  - rst overrides every other input.
- Reset mid-frame: the frame is aborted. serial_out returns high the next cycle and no tx_done is produced.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - serial_out=1.
  - On an edge with tx_start=1: tx_data loads the shift register, the period counter clears, state goes to START, serial_out<=0, tx_busy<=1.
- START:
  - serial_out=0 for BIT_PERIOD cycles.
  - When the period counter reaches BIT_PERIOD-1: counter clears, state goes to DATA, serial_out<=shift[0].
- DATA:
  - Each bit is held BIT_PERIOD cycles.
  - At the end of each period: shift register shifts right, bit index increments, serial_out<=next LSB.
  - After bit index 7 completes: state goes to STOP, serial_out<=1.
- STOP:
  - serial_out=1 for BIT_PERIOD cycles.
  - At the end: state goes to IDLE, tx_busy<=0, tx_done<=1 for exactly one cycle.
- Timing, with acceptance at edge E0 and cycle n meaning the n-th cycle after E0:
  - Start bit: cycles 1..BP.
  - Data bit i: cycles (i+1)*BP+1 .. (i+2)*BP.
  - Stop bit: cycles 9*BP+1 .. 10*BP.
  - tx_done: high in cycle 10*BP+1.
  - tx_busy: high in cycles 1..10*BP.
- Back-to-back frames:
  - tx_start held high during the tx_done cycle is accepted there, because the FSM is in IDLE.
  - The next start bit begins in cycle 10*BP+2, so the line stays high exactly one extra clock between frames.
  - Inter-frame gap is BIT_PERIOD+1 high cycles minimum.
- tx_start while not in IDLE is ignored: no queuing and no effect on the current frame.
- tx_data changes after acceptance do not alter the frame in flight.
- tx_start held high continuously produces continuous frames, each using tx_data as sampled at its acceptance edge.
- serial_out is glitch-free: it is driven only from a flop.

Test Plan:
1. Reset, then idle: rst=1 for 2 cycles, then rst=0, no start for 50 cycles -> serial_out=1, tx_busy=0, tx_done=0 throughout.
2. Single frame, BP=10, tx_data=8'hA5, tx_start pulsed 1 cycle -> serial_out by bit period: 0,1,0,1,0,0,1,0,1,1, each exactly 10 cycles. tx_busy high for 100 cycles. tx_done high only in cycle 101.
3. Back-to-back frames: tx_start held high with 8'h00 then 8'hFF -> second start bit begins in cycle 102. Line is high in cycle 101 only between the frames. Second frame pattern is 0, eight 1s, 1. Exactly two tx_done pulses.
4. Ignored request and data change: tx_start pulsed at cycle 40 with tx_data=8'h3C during a 8'h81 frame -> frame still sends 8'h81 (0,1,0,0,0,0,0,0,1,1). One tx_done only. Line returns to idle.
5. Reset mid-frame: rst=1 at cycle 55 of a frame -> from cycle 56 serial_out=1 and tx_busy=0. No tx_done. The next tx_start sends a full, correct frame.
6. Minimum period, BP=2, tx_data=8'h5A -> each bit lasts 2 cycles. Frame is 20 cycles. tx_done appears in cycle 21. A receiver model recovers 8'h5A with stop bit 1.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: 8N1 serial transmitter.
// Takes one byte per tx_start handshake and sends it as:
//   start bit (0), data bits LSB first, stop bit (1).
// Each bit is held for BIT_PERIOD clocks.
// serial_out, tx_busy and tx_done all come straight from flops.
module uart_tx_frame #(
  parameter int unsigned BIT_PERIOD = 10,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 serial_out
);

  localparam int unsigned CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   serial_q, serial_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   period_end;
  logic                   last_bit;

  // Marks the final clock of the bit currently on the line, and the last data bit
  always_comb begin
    period_end = (cnt_q == CNT_LAST);
    last_bit   = (idx_q == IDX_LAST);
  end

  // State register; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each non-idle phase advances only at the end of a bit period
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (period_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (period_end && last_bit) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (period_end) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values: line level, counters, shifter, busy/done flags
  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
        if (tx_start) begin
          shift_d  = tx_data;
          cnt_d    = '0;
          idx_d    = '0;
          serial_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      S_START: begin
        if (period_end) begin
          cnt_d    = '0;
          serial_d = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (period_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (last_bit) begin
            idx_d    = '0;
            serial_d = 1'b1;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            serial_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (period_end) begin
          cnt_d  = '0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset forces the line idle-high
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Ports driven only from flops
  always_comb begin
    serial_out = serial_q;
    tx_busy    = busy_q;
    tx_done    = done_q;
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two instances (BIT_PERIOD 10 and 2), a frame-level
// reference model, table-driven frame vectors and hand-written corner sequences.
module tb_uart_tx_frame;

  localparam int BP_A = 10;
  localparam int BP_B = 2;

  logic       clk;
  logic       rst;
  logic       start_a, start_b;
  logic [7:0] data_a, data_b;
  logic       busy_a, done_a, ser_a;
  logic       busy_b, done_b, ser_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic [0:9] pattern;  // expected line level for each of the 10 bit periods
  } vec_t;

  vec_t vecs[6];

  uart_tx_frame #(.BIT_PERIOD(BP_A), .DATA_BITS(8)) dut_a (
    .clk(clk), .rst(rst), .tx_start(start_a), .tx_data(data_a),
    .tx_busy(busy_a), .tx_done(done_a), .serial_out(ser_a)
  );

  uart_tx_frame #(.BIT_PERIOD(BP_B), .DATA_BITS(8)) dut_b (
    .clk(clk), .rst(rst), .tx_start(start_b), .tx_data(data_b),
    .tx_busy(busy_b), .tx_done(done_b), .serial_out(ser_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: position n inside a frame of 10*bp+1 cycles (last is the done cycle)
  logic       ma_act, mb_act;
  int         ma_n, mb_n;
  logic [7:0] ma_dat, mb_dat;

  always @(posedge clk) begin
    if (rst) begin
      ma_act <= 1'b0;
      ma_n   <= 0;
    end else if ((!ma_act || ma_n == 10*BP_A+1) && start_a) begin
      ma_act <= 1'b1;
      ma_n   <= 1;
      ma_dat <= data_a;
    end else if (ma_act) begin
      ma_act <= (ma_n != 10*BP_A+1);
      ma_n   <= ma_n + 1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      mb_act <= 1'b0;
      mb_n   <= 0;
    end else if ((!mb_act || mb_n == 10*BP_B+1) && start_b) begin
      mb_act <= 1'b1;
      mb_n   <= 1;
      mb_dat <= data_b;
    end else if (mb_act) begin
      mb_act <= (mb_n != 10*BP_B+1);
      mb_n   <= mb_n + 1;
    end
  end

  // Expected {serial, busy, done} at frame position n
  function automatic logic [2:0] model_out(input int bp, input logic act, input int n,
                                           input logic [7:0] d);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    if (!act) return 3'b100;
    if (n <= 10*bp) return {fr[4'((n-1)/bp)], 2'b10};
    return 3'b101;
  endfunction

  // Expected {serial, busy, done} at cycle c after acceptance, from a table pattern
  function automatic logic [2:0] pat_out(input int bp, input logic [0:9] pat, input int c);
    if (c >= 1 && c <= 10*bp) return {pat[4'((c-1)/bp)], 2'b10};
    if (c == 10*bp+1) return 3'b101;
    return 3'b100;
  endfunction

  function automatic logic [2:0] dut_out(input int sel);
    if (sel == 0) return {ser_a, busy_a, done_a};
    return {ser_b, busy_b, done_b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare both instances to the model
  task automatic tick();
    @(negedge clk);
    chk("model_bp10", 32'(dut_out(0)), 32'(model_out(BP_A, ma_act, ma_n, ma_dat)));
    chk("model_bp2",  32'(dut_out(1)), 32'(model_out(BP_B, mb_act, mb_n, mb_dat)));
  endtask

  task automatic drive(input int sel, input logic st, input logic [7:0] d);
    if (sel == 0) begin
      start_a = st;
      data_a  = d;
    end else begin
      start_b = st;
      data_b  = d;
    end
  endtask

  // Send one table vector and compare every cycle against its pattern
  task automatic run_vec(input int sel, input vec_t v);
    int bp;
    bp = (sel == 0) ? BP_A : BP_B;
    drive(sel, 1'b1, v.data);
    tick();
    drive(sel, 1'b0, ~v.data);
    for (int c = 1; c <= 10*bp + 3; c++) begin
      if (c > 1) tick();
      chk("vec_frame", 32'(dut_out(sel)), 32'(pat_out(bp, v.pattern, c)));
    end
  endtask

  int         done_cnt;
  logic [2:0] e;
  logic       line_b[0:21];
  logic [7:0] rx_byte;

  initial begin
    vecs[0] = '{8'hA5, 10'b0101001011};
    vecs[1] = '{8'h81, 10'b0100000011};
    vecs[2] = '{8'h00, 10'b0000000001};
    vecs[3] = '{8'hFF, 10'b0111111111};
    vecs[4] = '{8'h5A, 10'b0010110101};
    vecs[5] = '{8'h3C, 10'b0001111001};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; data_a = 8'h00; data_b = 8'h00;

    // Reset then idle
    tick();
    chk("reset_a", 32'(dut_out(0)), 32'h4);
    chk("reset_b", 32'(dut_out(1)), 32'h4);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_a", 32'(dut_out(0)), 32'h4);
    end

    // Table vectors on both periods
    for (int i = 0; i < 6; i++) run_vec(0, vecs[i]);
    for (int i = 0; i < 6; i++) run_vec(1, vecs[i]);

    // Back-to-back: 00 then FF with tx_start held through the done cycle
    done_cnt = 0;
    drive(0, 1'b1, 8'h00);
    tick();
    data_a = 8'hFF;
    for (int c = 1; c <= 215; c++) begin
      if (c > 1) tick();
      if (c <= 101) e = pat_out(BP_A, vecs[2].pattern, c);
      else e = pat_out(BP_A, vecs[3].pattern, c - 101);
      chk("b2b_frame", 32'(dut_out(0)), 32'(e));
      if (done_a) done_cnt++;
      if (c == 102) start_a = 1'b0;
    end
    chk("b2b_done_count", 32'(done_cnt), 32'd2);

    // Ignored request with data change mid-frame
    done_cnt = 0;
    drive(0, 1'b1, 8'h81);
    tick();
    start_a = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      if (c > 1) tick();
      chk("ignore_frame", 32'(dut_out(0)), 32'(pat_out(BP_A, vecs[1].pattern, c)));
      if (done_a) done_cnt++;
      if (c == 40) drive(0, 1'b1, 8'h3C);
      if (c == 41) start_a = 1'b0;
    end
    chk("ignore_done_count", 32'(done_cnt), 32'd1);

    // Reset mid-frame at cycle 55
    done_cnt = 0;
    drive(0, 1'b1, 8'hA5);
    tick();
    start_a = 1'b0;
    for (int c = 1; c <= 55; c++) begin
      if (c > 1) tick();
      chk("abort_pre", 32'(dut_out(0)), 32'(pat_out(BP_A, vecs[0].pattern, c)));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_c56", 32'(dut_out(0)), 32'h4);
    for (int c = 57; c <= 120; c++) begin
      tick();
      chk("abort_idle", 32'(dut_out(0)), 32'h4);
      if (done_a) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    run_vec(0, vecs[0]);

    // Minimum period: recover the byte with a receiver that samples each bit
    drive(1, 1'b1, 8'h5A);
    tick();
    drive(1, 1'b0, 8'h00);
    for (int c = 1; c <= 21; c++) begin
      if (c > 1) tick();
      line_b[5'(c)] = ser_b;
      if (c == 20) chk("bp2_busy_c20", 32'(busy_b), 32'd1);
      if (c == 21) chk("bp2_done_c21", 32'({busy_b, done_b}), 32'h1);
    end
    for (int k = 0; k < 8; k++) rx_byte[3'(k)] = line_b[5'((k+1)*BP_B + 2)];
    chk("bp2_start_bit", 32'(line_b[5'(2)]), 32'd0);
    chk("bp2_rx_byte", 32'(rx_byte), 32'h5A);
    chk("bp2_stop_bit", 32'(line_b[5'(9*BP_B + 2)]), 32'd1);

    // Randomized traffic, including continuous tx_start and rare resets
    for (int k = 0; k < 6000; k++) begin
      start_a = (k >= 2000 && k < 2600) ? 1'b1 : ($urandom_range(0, 99) < 3);
      data_a  = 8'($urandom);
      start_b = ($urandom_range(0, 9) < 3);
      data_b  = 8'($urandom);
      rst     = ($urandom_range(0, 1499) == 0);
      tick();
    end
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
    for (int k = 0; k < 120; k++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
